// File: rtl/div_unit.sv
// div_unit: iterative restoring radix-2 divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to retire |dividend| < |divisor| in a single cycle.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [CW-1:0]   cnt;
    logic            op_rem;
    logic            neg_q;
    logic            neg_r;

    // Request decode, used only on the accept edge
    logic            req_signed;
    logic            req_is_rem;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            ovf;
    logic            early;
    logic            fast;
    logic [XLEN-1:0] fast_val;

    always_comb begin
        req_signed = ~req_op[0];
        req_is_rem = req_op[1];
        abs_a      = (req_signed && req_a[XLEN-1]) ? -req_a : req_a;
        abs_b      = (req_signed && req_b[XLEN-1]) ? -req_b : req_b;
        div_zero   = (req_b == '0);
        ovf        = req_signed && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
`ifdef DIV_EARLY_OUT_EN
        early      = (abs_a < abs_b);
`else
        early      = 1'b0;
`endif
        fast       = div_zero || ovf || early;
        if (div_zero) begin
            fast_val = req_is_rem ? req_a : '1;
        end else if (ovf) begin
            fast_val = req_is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            fast_val = req_is_rem ? req_a : '0;
        end
    end

    // One restoring step; rem < divisor keeps the shifted value below 2*divisor,
    // so bit XLEN of the difference is a reliable borrow.
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            step_ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;

    always_comb begin
        rem_sh  = {rem, quo[XLEN-1]};
        diff    = rem_sh - {1'b0, divisor};
        step_ge = ~diff[XLEN];
        rem_nx  = step_ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx  = {quo[XLEN-2:0], step_ge};
        q_fin   = neg_q ? -quo_nx : quo_nx;
        r_fin   = neg_r ? -rem_nx : rem_nx;
    end

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            divisor     <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            op_rem      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
        end else if (flush) begin
            state       <= IDLE;
            resp_valid  <= 1'b0;
            resp_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_rem  <= req_is_rem;
                        neg_q   <= req_signed && (req_a[XLEN-1] ^ req_b[XLEN-1]);
                        neg_r   <= req_signed && req_a[XLEN-1];
                        divisor <= abs_b;
                        quo     <= abs_a;
                        rem     <= '0;
                        cnt     <= '0;
                        if (fast) begin
                            state       <= DONE;
                            resp_valid  <= 1'b1;
                            resp_result <= fast_val;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= DONE;
                        resp_valid  <= 1'b1;
                        resp_result <= op_rem ? r_fin : q_fin;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state       <= IDLE;
                        resp_valid  <= 1'b0;
                        resp_result <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed steps with a result/latency scoreboard queue.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] lat;
    } exp_t;

    exp_t sb[$];

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic        sgn;
        logic        is_rem;
        logic [31:0] ma;
        logic [31:0] mb;
        sgn    = !op[0];
        is_rem = op[1];
        if (b == 32'd0) begin
            e.res = is_rem ? a : 32'hFFFF_FFFF;
            e.lat = 32'd1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = is_rem ? 32'd0 : 32'h8000_0000;
            e.lat = 32'd1;
        end else begin
            if (sgn) e.res = is_rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
            else     e.res = is_rem ? a % b : a / b;
            e.lat = 32'd33;
            ma = (sgn && a[31]) ? -a : a;
            mb = (sgn && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
            if (ma < mb) e.lat = 32'd1;
`else
            if (ma < mb) e.lat = 32'd33;
`endif
        end
        return e;
    endfunction

    // Leaves the caller at the falling edge of cycle 1 after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_resp);
        @(negedge clk);
        check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        if (expect_resp) sb.push_back(model(op, a, b));
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_resp(input int hold);
        exp_t        e;
        int          lat;
        logic [31:0] held;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            check("result_zero_while_idle", resp_result, 32'd0);
            @(negedge clk);
            lat++;
        end
        check("resp_valid_seen", {31'd0, resp_valid}, 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("latency", lat, e.lat);
            check("result", resp_result, e.res);
        end
        check("req_ready_low_in_done", {31'd0, req_ready}, 32'd0);
        held = resp_result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_result", resp_result, held);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("valid_after_take", {31'd0, resp_valid}, 32'd0);
        check("result_after_take", resp_result, 32'd0);
        check("idle_after_take", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic expect_quiet(input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid || resp_result != 32'd0) seen++;
        end
        check(tag, seen, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = 32'd0;
        req_b      = 32'd0;
        resp_ready = 1'b0;
        #1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_resp_result", resp_result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Signed normal path
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_resp(0);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_resp(0);
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_resp(0);
        issue(OP_REM, 32'hFFFF_FF9C, 32'd7, 1'b1);
        wait_resp(0);

        // Divide by zero and signed overflow
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd0, 1'b1);
        wait_resp(0);
        issue(OP_REMU, 32'h0000_1234, 32'd0, 1'b1);
        wait_resp(0);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_resp(0);
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_resp(0);

        // Consumer backpressure
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
        wait_resp(5);

        // Flush mid-CALC, then a fresh operation
        issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {31'd0, req_ready}, 32'd1);
        expect_quiet("flush_no_resp");
        issue(OP_REMU, 32'd10, 32'd4, 1'b1);
        wait_resp(0);

        // Reset mid-CALC
        issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_calc_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_calc_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("rst_calc_no_resp");
        issue(OP_REMU, 32'd10, 32'd4, 1'b1);
        wait_resp(0);

        // Reset mid-DONE
        issue(OP_DIVU, 32'd5, 32'd0, 1'b0);
        check("done_before_rst", {31'd0, resp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_done_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_done_resp_result", resp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("rst_done_no_resp");

        // Flush wins over a simultaneous accept
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = 32'd9;
        req_b     = 32'd0;
        flush     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_blocks_accept", {31'd0, req_ready}, 32'd1);
        expect_quiet("flush_accept_no_resp");

        // Small dividend: latency depends on the early-out build
        issue(OP_DIVU, 32'd3, 32'd9, 1'b1);
        wait_resp(0);
        issue(OP_REM, 32'hFFFF_FFFD, 32'd9, 1'b1);
        wait_resp(0);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            issue(op, a, b, 1'b1);
            wait_resp(i % 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
